ysyx_22040931_ifu: RTL and testbench

//  Instruction fetch unit, directly downstream of the PC register. Takes the current PC and fetch

---
 rtl/ysyx_22040931_ifu_pkg.sv | 35 +++
 rtl/ysyx_22040931_ifu_if.sv | 36 +++
 rtl/ysyx_22040931_ifu.sv | 153 +++++++++++++++
 tb/tb_ysyx_22040931_ifu.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040931_ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               It holds the bus widths, the OKAY response code, the IFU
//               state encoding and two small fault-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040931_ifu_pkg;

    localparam int C_PC_BUS   = 64;
    localparam int C_DATA_BUS = 64;
    localparam int C_INST_W   = 32;

    localparam logic [1:0] C_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_t;

    // Any response other than OKAY is reported to decode as an access fault.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        return resp != C_RESP_OKAY;
    endfunction

    // Instructions are 4-byte aligned; any low-bit set is a misaligned fetch.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040931_ifu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040931_ifu_if
// Description : AXI-lite-style read channel (AR + R) between the IFU and the
//               instruction memory interconnect.
//               master : IFU side   (drives ar_valid/ar_addr/r_ready)
//               slave  : memory side (drives ar_ready/r_valid/r_data/r_resp)
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22040931_ifu_if
    import ysyx_22040931_ifu_pkg::*;
#(
    parameter int ADDR_W = C_PC_BUS,
    parameter int DATA_W = C_DATA_BUS
) ();

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_22040931_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040931_ifu
// Description : Instruction fetch unit. Latches the PC, issues one read on the
//               AR/R channel, selects the 32-bit half addressed by pc[2] and
//               presents it to decode under valid/ready. A flush squashes the
//               in-flight fetch; an already-issued read is still completed on
//               the bus and its data discarded.
// Ports       : clock, reset (async, active-low)
//               fetch_enb, pc_i, pc_ready_o, flush_i   - PC register side
//               bus (master)                           - AR/R read channel
//               inst_valid_o, inst_ready_i, inst_o,
//               inst_pc_o, inst_fault_o                - decode side
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040931_ifu
    import ysyx_22040931_ifu_pkg::*;
#(
    parameter int ADDR_W = C_PC_BUS,
    parameter int DATA_W = C_DATA_BUS,
    parameter int INST_W = C_INST_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fetch_enb,
    input  logic [ADDR_W-1:0]   pc_i,
    output logic                pc_ready_o,
    input  logic                flush_i,
    ysyx_22040931_ifu_if.master bus,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_pc_o,
    output logic                inst_fault_o
);

    ifu_state_t        r_state;
    ifu_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] w_inst_nxt;
    logic              r_fault;
    logic              w_fault_nxt;
    logic              r_drop;
    logic              w_drop_nxt;

    logic              w_ar_valid;
    logic              w_r_ready;
    logic              w_inst_valid;
    logic              w_discard;
    logic              w_resp_fault;
    logic [INST_W-1:0] w_word;

    // Upper half of the beat when pc[2] is set, lower half otherwise.
    assign w_word       = r_pc[2] ? bus.r_data[DATA_W-1 -: INST_W] : bus.r_data[INST_W-1:0];
    assign w_resp_fault = resp_is_fault(bus.r_resp);
    // A flush arriving in the same cycle as the response must also discard it:
    // the PC register has already moved to the redirect target on this edge.
    assign w_discard    = r_drop | flush_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IFU_IDLE;
            r_pc    <= '0;
            r_inst  <= '0;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_inst_nxt   = r_inst;
        w_fault_nxt  = r_fault;
        w_drop_nxt   = r_drop;
        w_ar_valid   = 1'b0;
        w_r_ready    = 1'b0;
        w_inst_valid = 1'b0;

        case (r_state)
            IFU_IDLE: begin
                if (fetch_enb && !flush_i) begin
                    w_pc_nxt = pc_i;
                    if (pc_misaligned(pc_i[1:0])) begin
                        // Misaligned: report the fault without touching the bus.
                        w_inst_nxt  = '0;
                        w_fault_nxt = 1'b1;
                        w_state_nxt = IFU_HOLD;
                    end else begin
                        w_state_nxt = IFU_ADDR;
                    end
                end
            end
            IFU_ADDR: begin
                // AR stays raised even after a flush; the read is only marked dropped.
                w_ar_valid = 1'b1;
                if (flush_i) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus.ar_ready) begin
                    w_state_nxt = IFU_DATA;
                end
            end
            IFU_DATA: begin
                w_r_ready = 1'b1;
                if (flush_i) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus.r_valid) begin
                    if (w_discard) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = IFU_IDLE;
                    end else begin
                        w_inst_nxt  = w_resp_fault ? '0 : w_word;
                        w_fault_nxt = w_resp_fault;
                        w_state_nxt = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                w_inst_valid = 1'b1;
                if (flush_i || inst_ready_i) begin
                    w_state_nxt = IFU_IDLE;
                end
            end
            default: begin
                w_state_nxt = IFU_IDLE;
            end
        endcase
    end

    assign bus.ar_valid = w_ar_valid;
    assign bus.ar_addr  = {r_pc[ADDR_W-1:3], 3'b000};
    assign bus.r_ready  = w_r_ready;

    assign inst_valid_o = w_inst_valid;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_pc;
    assign inst_fault_o = r_fault;

    // One pulse per retired fetch or accepted redirect; never while in reset.
    assign pc_ready_o = reset & (((r_state == IFU_HOLD) & inst_ready_i) | flush_i);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040931_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040931_ifu
// Description : Self-checking bench for the instruction fetch unit. A memory
//               responder with configurable latency drives the read channel;
//               expected instructions come from a fixed address->data rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040931_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_enb;
    logic [63:0] pc_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    // responder configuration and state
    int          ar_delay    = 0;
    int          r_delay     = 0;
    bit          rand_delay  = 0;
    int          resp_mode   = 0;   // 0 OKAY, 1 always SLVERR, 2 by address
    bit          fixed_data  = 0;
    logic [63:0] fixed_word  = 64'h0;
    logic [63:0] pend_addr   = 64'h0;
    bit          pending     = 0;
    int          ar_cnt      = 0;
    int          r_cnt       = 0;
    int          ar_hs_count = 0;

    ysyx_22040931_ifu_if bus ();

    ysyx_22040931_ifu dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_enb    (fetch_enb),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .bus          (bus),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_fault_o (inst_fault_o)
    );

    always #5 clock = ~clock;

    // ---------------- reference rules ----------------
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
    endfunction

    function automatic logic ref_fault(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || (pc[6:3] == 4'hF);
    endfunction

    function automatic logic [31:0] ref_inst(input logic [63:0] pc, input logic flt);
        logic [63:0] w;
        w = mem_word({pc[63:3], 3'b000});
        if (flt) return 32'h0;
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_data   = 64'h0;
        bus.r_resp   = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            bus.ar_ready = 1'b0;
            bus.r_valid  = 1'b0;
            bus.r_resp   = 2'b00;
            bus.r_data   = 64'hDEAD_BEEF_DEAD_BEEF;
            if (!reset) begin
                pending = 0;
                ar_cnt  = 0;
                r_cnt   = 0;
            end else begin
                if (bus.r_ready && pending) begin
                    if (r_cnt >= r_delay) begin
                        bus.r_valid = 1'b1;
                        bus.r_data  = fixed_data ? fixed_word : mem_word(pend_addr);
                        case (resp_mode)
                            1:       bus.r_resp = 2'b10;
                            2:       bus.r_resp = (pend_addr[6:3] == 4'hF) ? 2'b10 : 2'b00;
                            default: bus.r_resp = 2'b00;
                        endcase
                        pending = 0;
                        r_cnt   = 0;
                        if (rand_delay) r_delay = $urandom_range(3, 0);
                    end else begin
                        r_cnt++;
                    end
                end
                if (bus.ar_valid && !pending) begin
                    if (ar_cnt >= ar_delay) begin
                        bus.ar_ready = 1'b1;
                        pend_addr    = bus.ar_addr;
                        pending      = 1;
                        ar_cnt       = 0;
                        ar_hs_count++;
                        if (rand_delay) ar_delay = $urandom_range(3, 0);
                    end else begin
                        ar_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    // One complete fetch with decode ready, starting in IDLE at posedge+1.
    task automatic fetch_one(input logic [63:0] pc, input logic [31:0] exp_inst,
                             input logic exp_fault, input int exp_cycles, input bit exp_bus);
        int          cyc;
        bit          done, seen_ar, unstable, early;
        logic [63:0] first_addr;
        cyc = 0; done = 0; seen_ar = 0; unstable = 0; early = 0; first_addr = 64'h0;
        pc_i = pc; fetch_enb = 1'b1; inst_ready_i = 1'b1; flush_i = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (bus.ar_valid) begin
                if (!seen_ar) begin
                    seen_ar = 1; first_addr = bus.ar_addr;
                end else if (bus.ar_addr !== first_addr) begin
                    unstable = 1;
                end
            end
            if (inst_valid_o) begin
                done = 1;
                n_checks++; if (inst_o !== exp_inst) begin n_fail++; $display("FAIL fetch_inst pc=%h: got %h expected %h", pc, inst_o, exp_inst); end
                n_checks++; if (inst_pc_o !== pc) begin n_fail++; $display("FAIL fetch_inst_pc: got %h expected %h", inst_pc_o, pc); end
                n_checks++; if (inst_fault_o !== exp_fault) begin n_fail++; $display("FAIL fetch_fault pc=%h: got %b expected %b", pc, inst_fault_o, exp_fault); end
                n_checks++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL fetch_pc_ready pc=%h: got %b expected 1", pc, pc_ready_o); end
            end else if (pc_ready_o) begin
                early = 1;
            end
            @(posedge clock);
            #1;
            if (done) fetch_enb = 1'b0;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL fetch_timeout pc=%h: got no inst_valid expected within 40 cycles", pc); end
        n_checks++; if (cyc != exp_cycles) begin n_fail++; $display("FAIL fetch_cycles pc=%h: got %0d expected %0d", pc, cyc, exp_cycles); end
        n_checks++; if (seen_ar != exp_bus) begin n_fail++; $display("FAIL fetch_bus_access pc=%h: got %0d expected %0d", pc, seen_ar, exp_bus); end
        if (exp_bus) begin
            n_checks++; if (first_addr !== {pc[63:3], 3'b000}) begin n_fail++; $display("FAIL fetch_ar_addr: got %h expected %h", first_addr, {pc[63:3], 3'b000}); end
        end
        n_checks++; if (unstable) begin n_fail++; $display("FAIL fetch_ar_stable pc=%h: got changing address expected stable", pc); end
        n_checks++; if (early) begin n_fail++; $display("FAIL fetch_early_pc_ready pc=%h: got pulse before HOLD expected none", pc); end
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_enb = 1'b1; flush_i = 1'b1; inst_ready_i = 1'b1; pc_i = 64'h8000_0000;
        repeat (3) @(negedge clock);
        n_checks++; if ({bus.ar_valid, bus.r_ready, inst_valid_o, inst_fault_o} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.ar_valid, bus.r_ready, inst_valid_o, inst_fault_o}); end
        n_checks++; if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready_o); end
        n_checks++; if ({inst_o, inst_pc_o, bus.ar_addr} !== 160'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", inst_o, inst_pc_o, bus.ar_addr); end
        @(posedge clock); #1;
        reset = 1'b1; flush_i = 1'b0; fetch_enb = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_no_fetch: got %b expected 0", bus.ar_valid); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        ar_delay = 0; r_delay = 0; resp_mode = 0;
        fixed_data = 1; fixed_word = 64'h0000_0013_0010_0093;
        fetch_one(64'h8000_0000, 32'h0010_0093, 1'b0, 4, 1);
        fetch_one(64'h8000_0004, 32'h0000_0013, 1'b0, 4, 1);
        fixed_data = 0;
    endtask

    task automatic test_delays();
        ar_delay = 3; r_delay = 2;
        fetch_one(64'h8000_0010, ref_inst(64'h8000_0010, 1'b0), 1'b0, 9, 1);
        fetch_one(64'h8000_0014, ref_inst(64'h8000_0014, 1'b0), 1'b0, 9, 1);
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_fault();
        fetch_one(64'h8000_0002, 32'h0, 1'b1, 2, 0);
        resp_mode = 1;
        fetch_one(64'h8000_0008, 32'h0, 1'b1, 4, 1);
        resp_mode = 0;
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        bit          seen;
        exp = ref_inst(64'h8000_0020, 1'b0);
        seen = 0;
        pc_i = 64'h8000_0020; fetch_enb = 1'b1; inst_ready_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (inst_valid_o) seen = 1;
            else begin @(posedge clock); #1; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_timeout: got no inst_valid expected HOLD"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            n_checks++;
            if ({inst_valid_o, pc_ready_o, inst_o, inst_pc_o} !== {1'b1, 1'b0, exp, 64'h8000_0020}) begin
                n_fail++; $display("FAIL stall_hold cycle %0d: got v=%b r=%b %h %h expected v=1 r=0 %h 80000020", i, inst_valid_o, pc_ready_o, inst_o, inst_pc_o, exp);
            end
        end
        @(posedge clock); #1;
        inst_ready_i = 1'b1;
        @(negedge clock);
        n_checks++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_pc_ready: got %b expected 1", pc_ready_o); end
        @(posedge clock); #1;
        fetch_enb = 1'b0;
        @(negedge clock);
        n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_after_accept_valid: got %b expected 0", inst_valid_o); end
        @(posedge clock); #1;
    endtask

    task automatic test_flush();
        int  hs0, cyc;
        bit  done, extra;
        // flush while AR is waiting for ready
        ar_delay = 2; r_delay = 1;
        hs0 = ar_hs_count;
        pc_i = 64'h8000_0040; fetch_enb = 1'b1; inst_ready_i = 1'b1; flush_i = 1'b0;
        @(posedge clock); #1;
        flush_i = 1'b1;
        @(negedge clock);
        n_checks++; if ({pc_ready_o, bus.ar_valid} !== 2'b11) begin n_fail++; $display("FAIL flush_addr_pulse: got ready=%b ar_valid=%b expected 1 1", pc_ready_o, bus.ar_valid); end
        @(posedge clock); #1;
        flush_i = 1'b0; pc_i = 64'h8000_0100;
        @(negedge clock);
        n_checks++; if (bus.ar_valid !== 1'b1) begin n_fail++; $display("FAIL flush_ar_held: got %b expected 1", bus.ar_valid); end
        done = 0; extra = 0; cyc = 0;
        while (!done && cyc < 40) begin
            if (inst_valid_o) begin
                done = 1;
                n_checks++; if (inst_pc_o !== 64'h8000_0100) begin n_fail++; $display("FAIL flush_new_pc: got %h expected 80000100", inst_pc_o); end
                n_checks++; if (inst_o !== ref_inst(64'h8000_0100, 1'b0)) begin n_fail++; $display("FAIL flush_new_inst: got %h expected %h", inst_o, ref_inst(64'h8000_0100, 1'b0)); end
            end else if (pc_ready_o) begin
                extra = 1;
            end
            @(posedge clock); #1;
            if (done) fetch_enb = 1'b0;
            else begin @(negedge clock); cyc++; end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL flush_timeout: got no inst_valid expected redirected fetch"); end
        n_checks++; if (extra) begin n_fail++; $display("FAIL flush_extra_pc_ready: got extra pulse expected none"); end
        n_checks++; if (ar_hs_count - hs0 != 2) begin n_fail++; $display("FAIL flush_ar_count: got %0d expected 2", ar_hs_count - hs0); end

        // flush together with inst_ready in HOLD
        ar_delay = 0; r_delay = 0;
        pc_i = 64'h8000_0200; fetch_enb = 1'b1; inst_ready_i = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (inst_valid_o) done = 1;
            else begin @(posedge clock); #1; end
        end
        @(posedge clock); #1;
        flush_i = 1'b1; inst_ready_i = 1'b1;
        @(negedge clock);
        n_checks++; if ({pc_ready_o, inst_valid_o, done} !== 3'b111) begin n_fail++; $display("FAIL flush_hold_pulse: got ready=%b valid=%b held=%b expected 1 1 1", pc_ready_o, inst_valid_o, done); end
        @(posedge clock); #1;
        flush_i = 1'b0; fetch_enb = 1'b0; pc_i = 64'h8000_0300;
        @(negedge clock);
        n_checks++; if ({inst_valid_o, bus.ar_valid, pc_ready_o} !== 3'b000) begin n_fail++; $display("FAIL flush_hold_dropped: got v=%b ar=%b r=%b expected 0 0 0", inst_valid_o, bus.ar_valid, pc_ready_o); end
        @(posedge clock); #1;
        fetch_one(64'h8000_0300, ref_inst(64'h8000_0300, 1'b0), 1'b0, 4, 1);

        // flush in IDLE with fetch_enb: nothing starts
        pc_i = 64'h8000_0400; fetch_enb = 1'b1; flush_i = 1'b1;
        @(negedge clock);
        n_checks++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_idle_pulse: got %b expected 1", pc_ready_o); end
        @(posedge clock); #1;
        flush_i = 1'b0; fetch_enb = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.ar_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_no_fetch: got %b expected 0", bus.ar_valid); end
        @(posedge clock); #1;
    endtask

    task automatic test_async_reset();
        bit seen;
        ar_delay = 0; r_delay = 3; seen = 0;
        pc_i = 64'h8000_0500; fetch_enb = 1'b1; inst_ready_i = 1'b1; flush_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (bus.r_ready) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL areset_reach_data: got no r_ready expected DATA"); end
        #2;
        reset = 1'b0; fetch_enb = 1'b0;
        #1;
        n_checks++; if ({bus.ar_valid, bus.r_ready, inst_valid_o, pc_ready_o, inst_fault_o} !== 5'b0) begin n_fail++; $display("FAIL areset_ctrl: got %b expected 00000", {bus.ar_valid, bus.r_ready, inst_valid_o, pc_ready_o, inst_fault_o}); end
        n_checks++; if ({inst_o, inst_pc_o, bus.ar_addr} !== 160'h0) begin n_fail++; $display("FAIL areset_data: got %h %h %h expected 0", inst_o, inst_pc_o, bus.ar_addr); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1; r_delay = 0;
        @(posedge clock); #1;
        fetch_one(64'h8000_0508, ref_inst(64'h8000_0508, 1'b0), 1'b0, 4, 1);
    endtask

    task automatic test_random();
        logic [63:0] pc_reg, target;
        logic        fl, take;
        int          retired;
        retired = 0;
        rand_delay = 1; resp_mode = 2; fixed_data = 0;
        pc_reg = 64'h8000_1000;
        for (int c = 0; c < 2000; c++) begin
            fl = ($urandom_range(24, 0) == 0);
            target = 64'h8000_0000 + 64'($urandom_range(255, 0)) * 64'd4
                   + (($urandom_range(7, 0) == 0) ? 64'd2 : 64'd0);
            fetch_enb    = ($urandom_range(9, 0) < 8);
            inst_ready_i = ($urandom_range(9, 0) < 6);
            flush_i      = fl;
            pc_i         = pc_reg;
            @(negedge clock);
            take = inst_valid_o & inst_ready_i;
            n_checks++;
            if (pc_ready_o !== (fl | take)) begin n_fail++; $display("FAIL rand_pc_ready c=%0d: got %b expected %b", c, pc_ready_o, fl | take); end
            if (inst_valid_o && !fl) begin
                n_checks++;
                if ({inst_pc_o, inst_o, inst_fault_o} !== {pc_reg, ref_inst(pc_reg, ref_fault(pc_reg)), ref_fault(pc_reg)}) begin
                    n_fail++;
                    $display("FAIL rand_inst c=%0d: got pc=%h inst=%h f=%b expected pc=%h inst=%h f=%b", c, inst_pc_o, inst_o, inst_fault_o, pc_reg, ref_inst(pc_reg, ref_fault(pc_reg)), ref_fault(pc_reg));
                end
            end
            if (take && !fl) retired++;
            @(posedge clock); #1;
            if (fl) pc_reg = target;
            else if (take) pc_reg = pc_reg + 64'd4;
        end
        flush_i = 1'b0; fetch_enb = 1'b0;
        n_checks++; if (retired < 40) begin n_fail++; $display("FAIL rand_progress: got %0d retired expected at least 40", retired); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delays();
        test_fault();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
